vscale_tohost_monitor: RTL and testbench
========================================

// Module: vscale_tohost_monitor
// PURPOSE
//  Synthesizable, multi-channel tohost watcher. Snoops one data-memory write port per hart,
//  registers writes to TOHOST_ADDR, and resolves run status to PASS/FAIL/TIMEOUT.
//  Sits beside vscale_sim_top cores, for FPGA/emulation runs without a simulator $finish.
//  Reports a sticky verdict, failing channel, tohost code and cycle stamp.
// PARAMETERS
//  NUM_CH       1            number of monitored write ports (harts), 1..8
//  ADDR_WIDTH   32           dmem address width
//  DATA_WIDTH   32           dmem write-data width (tohost word)
//  TOHOST_ADDR  32'h00001000 full-word match address, same for all channels
//  CNT_WIDTH    64           cycle counter width
// PORTS
//  clk           in   1                    clock
//  reset_n       in   1                    async active-low reset
//  ch_enable     in   NUM_CH               channels required to pass; sampled every cycle
//  max_cycles    in   CNT_WIDTH            timeout limit; 0 = no timeout
//  dmem_write    in   NUM_CH               per-channel write strobe
//  dmem_addr     in   NUM_CH*ADDR_WIDTH    packed addresses, ch0 in LSBs
//  dmem_wdata    in   NUM_CH*DATA_WIDTH    packed write data, ch0 in LSBs
//  done          out  1                    verdict reached (sticky)
//  passed        out  1                    verdict = PASS
//  failed        out  1                    verdict = FAIL
//  timed_out     out  1                    verdict = TIMEOUT
//  fail_ch       out  $clog2(NUM_CH)+1     failing channel index
//  fail_code     out  DATA_WIDTH-1         tohost value >> 1 of failing write
//  pass_mask     out  NUM_CH               channels that have written 1
//  cycle_count   out  CNT_WIDTH            cycles since reset release, saturating
//  finish_cycle  out  CNT_WIDTH            cycle_count value when done rose
// BEHAVIOUR
//  - Clock and reset: one clock domain; reset is asynchronous and active-low. While
//    reset_n=0 every output and internal register is 0, and state is RUN.
//  - Stage 1 (edge E): hit[i] <= dmem_write[i] & (dmem_addr[i]==TOHOST_ADDR);
//    val[i] <= dmem_wdata[i]. Stage 2 (edge E+1): evaluate and update state and outputs.
//    Write-to-verdict latency is 2 edges.
//  - Only hits with val[i] != 0 count; a zero write is ignored. Channels with
//    ch_enable[i]=0 are ignored entirely, including fail writes.
//  - val==1 sets pass_mask[i], which is sticky. A repeated 1 has no further effect.
//  - Any other nonzero val is a fail event.
//  - cycle_count: +1 each edge after reset release, saturates at all-ones, freezes when done=1.
//  - FSM states RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset;
//    all inputs are ignored there.
//  - RUN->FAIL: any enabled fail event. Lowest enabled index wins on simultaneous fails.
//    Sets fail_ch=i and fail_code=val[i][DATA_WIDTH-1:1].
//  - RUN->PASS: (pass_mask_next & ch_enable) == ch_enable and ch_enable != 0.
//  - RUN->TIMEOUT: max_cycles != 0 and cycle_count >= max_cycles.
//  - Priority in the same evaluation edge: FAIL > PASS > TIMEOUT.
//  - On entering any terminal state: done=1, the matching flag =1, finish_cycle=cycle_count.
//  - fail_ch and fail_code are 0 unless state is FAIL.
//  - If ch_enable drops a pending channel mid-run, PASS may fire on the next evaluation.
//  - ch_enable=0 with max_cycles=0: remains in RUN forever.
//  - Reset asserted mid-run or in a terminal state clears all state immediately.
// TESTING
//  1. NUM_CH=1, ch_enable=1: write 1 to 0x1000 at cycle 10 -> done=passed=1 two edges later;
//     finish_cycle=11; other flags 0.
//  2. NUM_CH=1: write 0x2B to 0x1000 -> failed=1, fail_code=0x15, fail_ch=0.
//     A later write of 1 does not change the verdict.
//  3. Write 1 to 0x1004 and write 0 to 0x1000 -> no verdict.
//     max_cycles=50 -> timed_out=1 with finish_cycle=50.
//  4. NUM_CH=4, ch_enable=4'b1011: ch0, ch1 and ch3 write 1 in separate cycles -> PASS only
//     after ch3 writes; pass_mask=4'b1011. A ch2 fail write (0x7) is ignored.
//  5. NUM_CH=4, same edge: ch1 writes 0x9, ch2 writes 0x5, ch3 completes pass_mask, and
//     timeout is also due -> FAIL with fail_ch=1, fail_code=4.
//  6. Assert reset_n=0 asynchronously mid-cycle while in FAIL -> all outputs 0 without a
//     clock edge. After release, cycle_count restarts at 0 and a pass of 1 passes normally.

Source files
------------

// File: rtl/vscale_tohost_monitor.sv
// vscale_tohost_monitor
//   Watches one dmem write port per hart for stores to TOHOST_ADDR and turns
//   them into a sticky PASS / FAIL / TIMEOUT verdict, for emulation runs that
//   have no simulator $finish to rely on.
// Ports
//   clk, reset_n              clock, async active-low reset
//   ch_enable[NUM_CH]         channels that must write 1 for PASS
//   max_cycles                timeout limit, 0 disables the timeout
//   dmem_write/addr/wdata     per-channel write ports, packed with ch0 in the LSBs
//   done/passed/failed/timed_out  verdict flags
//   fail_ch, fail_code        failing channel and its tohost value >> 1
//   pass_mask                 channels that have written 1
//   cycle_count, finish_cycle free-running (saturating) count and its value at the verdict

// Per-channel snoop stage: registers the tohost hit and the written word.
module vscale_tohost_lane #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  hit_q,
  output logic [DATA_WIDTH-1:0] val_q
);
  logic                  hit_d;
  logic [DATA_WIDTH-1:0] val_d;

  always_comb begin
    hit_d = write & (addr == TOHOST_ADDR);
    val_d = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= 1'b0;
      val_q <= '0;
    end else begin
      hit_q <= hit_d;
      val_q <= val_d;
    end
  end
endmodule

module vscale_tohost_monitor #(
  parameter int          NUM_CH      = 1,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int          CNT_WIDTH   = 64,
  localparam int         FCW         = $clog2(NUM_CH) + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [CNT_WIDTH-1:0]         max_cycles,
  input  logic [NUM_CH-1:0]            dmem_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] dmem_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dmem_wdata,
  output logic                         done,
  output logic                         passed,
  output logic                         failed,
  output logic                         timed_out,
  output logic [FCW-1:0]               fail_ch,
  output logic [DATA_WIDTH-2:0]        fail_code,
  output logic [NUM_CH-1:0]            pass_mask,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [CNT_WIDTH-1:0]         finish_cycle
);
  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_e;

  logic [NUM_CH-1:0]                 hit;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] val;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    vscale_tohost_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .TOHOST_ADDR(TOHOST_ADDR)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .write  (dmem_write[g]),
      .addr   (dmem_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata  (dmem_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .hit_q  (hit[g]),
      .val_q  (val[g])
    );
  end

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     pass_mask_q, pass_mask_d;
  logic [FCW-1:0]        fail_ch_q, fail_ch_d;
  logic [DATA_WIDTH-2:0] fail_code_q, fail_code_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_WIDTH-1:0]  finish_cycle_q, finish_cycle_d;
  logic [NUM_CH-1:0]     pass_evt, fail_evt;

  always_comb begin
    state_d        = state_q;
    pass_mask_d    = pass_mask_q;
    fail_ch_d      = fail_ch_q;
    fail_code_d    = fail_code_q;
    cycle_count_d  = cycle_count_q;
    finish_cycle_d = finish_cycle_q;

    // Disabled channels are invisible; zero writes are not events at all.
    for (int i = 0; i < NUM_CH; i++) begin
      pass_evt[i] = hit[i] & ch_enable[i] & (val[i] == DATA_WIDTH'(1));
      fail_evt[i] = hit[i] & ch_enable[i] & (val[i] != '0) & (val[i] != DATA_WIDTH'(1));
    end

    if (state_q == ST_RUN) begin
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
      pass_mask_d = pass_mask_q | pass_evt;

      if (|fail_evt) begin
        state_d        = ST_FAIL;
        finish_cycle_d = cycle_count_q;
        // Walk downwards so the lowest failing index is the one left standing.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (fail_evt[i]) begin
            fail_ch_d   = FCW'(i);
            fail_code_d = val[i][DATA_WIDTH-1:1];
          end
        end
      end else if (((pass_mask_d & ch_enable) == ch_enable) && (ch_enable != '0)) begin
        state_d        = ST_PASS;
        finish_cycle_d = cycle_count_q;
      end else if ((max_cycles != '0) && (cycle_count_q >= max_cycles)) begin
        state_d        = ST_TIMEOUT;
        finish_cycle_d = cycle_count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      pass_mask_q    <= '0;
      fail_ch_q      <= '0;
      fail_code_q    <= '0;
      cycle_count_q  <= '0;
      finish_cycle_q <= '0;
    end else begin
      state_q        <= state_d;
      pass_mask_q    <= pass_mask_d;
      fail_ch_q      <= fail_ch_d;
      fail_code_q    <= fail_code_d;
      cycle_count_q  <= cycle_count_d;
      finish_cycle_q <= finish_cycle_d;
    end
  end

  assign done         = (state_q != ST_RUN);
  assign passed       = (state_q == ST_PASS);
  assign failed       = (state_q == ST_FAIL);
  assign timed_out    = (state_q == ST_TIMEOUT);
  assign fail_ch      = fail_ch_q;
  assign fail_code    = fail_code_q;
  assign pass_mask    = pass_mask_q;
  assign cycle_count  = cycle_count_q;
  assign finish_cycle = finish_cycle_q;
endmodule

// File: tb/tb_vscale_tohost_monitor.sv
module tb_vscale_tohost_monitor;
  localparam logic [31:0] TH = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // single-channel instance
  logic        en1, wr1;
  logic [63:0] max1;
  logic [31:0] addr1, wdata1;
  logic        done1, pass1, fail1, to1;
  logic [0:0]  fch1;
  logic [30:0] fcode1;
  logic [0:0]  pmask1;
  logic [63:0] cc1, fc1;

  // four-channel instance
  logic [3:0]   en4, wr4;
  logic [63:0]  max4;
  logic [127:0] addr4, wdata4;
  logic         done4, pass4, fail4, to4;
  logic [2:0]   fch4;
  logic [30:0]  fcode4;
  logic [3:0]   pmask4;
  logic [63:0]  cc4, fc4;

  vscale_tohost_monitor #(.NUM_CH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .ch_enable(en1), .max_cycles(max1),
    .dmem_write(wr1), .dmem_addr(addr1), .dmem_wdata(wdata1),
    .done(done1), .passed(pass1), .failed(fail1), .timed_out(to1),
    .fail_ch(fch1), .fail_code(fcode1), .pass_mask(pmask1),
    .cycle_count(cc1), .finish_cycle(fc1));

  vscale_tohost_monitor #(.NUM_CH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .ch_enable(en4), .max_cycles(max4),
    .dmem_write(wr4), .dmem_addr(addr4), .dmem_wdata(wdata4),
    .done(done4), .passed(pass4), .failed(fail4), .timed_out(to4),
    .fail_ch(fch4), .fail_code(fcode4), .pass_mask(pmask4),
    .cycle_count(cc4), .finish_cycle(fc4));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    wr4 = '0;   addr4 = '0; wdata4 = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic wr_ch1(input logic [31:0] a, input logic [31:0] d);
    wr1 = 1'b1; addr1 = a; wdata1 = d;
    tick();
    wr1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic set_ch4(input int ch, input logic [31:0] a, input logic [31:0] d);
    wr4[ch] = 1'b1;
    addr4[ch*32 +: 32]  = a;
    wdata4[ch*32 +: 32] = d;
  endtask

  initial begin
    en1 = 1'b1; max1 = '0;
    en4 = '0;   max4 = '0;
    idle_inputs();

    // reset state
    tick(2);
    chk("rst_done", done1, 0);
    chk("rst_cc", cc1, 0);
    chk("rst_pm4", pmask4, 0);

    // 1: pass at cycle 10
    do_reset();
    tick(10);
    chk("t1_cc10", cc1, 10);
    wr_ch1(TH, 32'h1);
    chk("t1_not_yet", done1, 0);
    tick();
    chk("t1_done", done1, 1);
    chk("t1_passed", pass1, 1);
    chk("t1_flags", {fail1, to1}, 0);
    chk("t1_finish", fc1, 11);
    chk("t1_pmask", pmask1, 1);
    tick(3);
    chk("t1_cc_frozen", cc1, 12);

    // 2: fail code 0x2B -> 0x15, later pass write ignored
    do_reset();
    wr_ch1(TH, 32'h2B);
    tick();
    chk("t2_failed", fail1, 1);
    chk("t2_code", fcode1, 31'h15);
    chk("t2_ch", fch1, 0);
    wr_ch1(TH, 32'h1);
    tick(2);
    chk("t2_sticky", {done1, pass1, fail1, to1}, 4'b1010);
    chk("t2_pmask", pmask1, 0);

    // 3: wrong address and zero write ignored, then timeout at 50
    do_reset();
    max1 = 64'd50;
    wr_ch1(TH + 32'h4, 32'h1);
    wr_ch1(TH, 32'h0);
    tick(2);
    chk("t3_no_verdict", done1, 0);
    chk("t3_pmask", pmask1, 0);
    begin
      int n = 0;
      while (!done1 && n < 200) begin tick(); n++; end
    end
    chk("t3_timed_out", to1, 1);
    chk("t3_other", {pass1, fail1}, 0);
    chk("t3_finish", fc1, 50);
    chk("t3_cc", cc1, 51);
    max1 = '0;

    // 4: 4 channels, enable 1011, ch2 fail write ignored
    do_reset();
    en4 = 4'b1011;
    set_ch4(0, TH, 32'h1); tick(); idle_inputs(); tick();
    set_ch4(1, TH, 32'h1); tick(); idle_inputs(); tick();
    set_ch4(2, TH, 32'h7); tick(); idle_inputs(); tick(2);
    chk("t4_pending", done4, 0);
    chk("t4_pmask_part", pmask4, 4'b0011);
    set_ch4(3, TH, 32'h1); tick(); idle_inputs(); tick();
    chk("t4_passed", {done4, pass4, fail4, to4}, 4'b1100);
    chk("t4_pmask", pmask4, 4'b1011);

    // 5: simultaneous fail/pass/timeout -> lowest fail wins
    do_reset();
    en4 = 4'b1111;
    set_ch4(0, TH, 32'h1); set_ch4(1, TH, 32'h1); set_ch4(2, TH, 32'h1);
    tick(); idle_inputs(); tick();
    chk("t5_pm", pmask4, 4'b0111);
    chk("t5_cc", cc4, 2);
    max4 = 64'd3;
    set_ch4(1, TH, 32'h9); set_ch4(2, TH, 32'h5); set_ch4(3, TH, 32'h1);
    tick(); idle_inputs(); tick();
    chk("t5_failed", {done4, pass4, fail4, to4}, 4'b1010);
    chk("t5_ch", fch4, 1);
    chk("t5_code", fcode4, 4);
    chk("t5_finish", fc4, 3);

    // 6: async reset mid-cycle while in FAIL
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_flags", {done4, pass4, fail4, to4}, 0);
    chk("t6_fail_info", {fch4, fcode4}, 0);
    chk("t6_cnts", {cc4, fc4} == '0, 1);
    chk("t6_pm", pmask4, 0);
    max4 = '0;
    en4 = 4'b0001;
    idle_inputs();
    tick();
    reset_n = 1'b1;
    chk("t6_cc0", cc4, 0);
    set_ch4(0, TH, 32'h1); tick(); idle_inputs(); tick();
    chk("t6_passed", {done4, pass4, fail4, to4}, 4'b1100);
    chk("t6_finish", fc4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
